// File: rtl/add_shift_add_pipe.sv
// rtl/add_shift_add_pipe.sv - streaming 3-stage Q = ((A+B) << SHIFT) + C with valid/ready flow control
// Optional build macro: ADD_SHIFT_SAT_EN (saturate q to all ones and flag ovf when the result exceeds OW bits)
module add_shift_add_pipe #(
    parameter int W     = 32,
    parameter int SHIFT = 2,
    parameter int OW    = 36,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    a_in,
    input  logic [W-1:0]    b_in,
    input  logic [W-1:0]    c_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   q,
    output logic            ovf,
    output logic [CNTW-1:0] out_count
);

    localparam int FW  = W + SHIFT + 2;
    localparam int S1W = W + 1 + SHIFT;

    logic            v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic [W-1:0]    a0_q, a0_d, b0_q, b0_d, c0_q, c0_d;
    logic [S1W-1:0]  s1_q, s1_d;
    logic [W-1:0]    c1_q, c1_d;
    logic [OW-1:0]   q_q, q_d;
    logic            ovf_q, ovf_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            rdy0, rdy1, rdy2;
    logic [W:0]      sum_ab;
    logic [S1W-1:0]  s1_w;
    logic [FW-1:0]   full_w;
    logic [OW-1:0]   q_red;
    logic            ovf_red;

    // A stage may load whenever it is empty or its contents move on this cycle
    always_comb begin
        rdy2 = !v2_q || out_ready;
        rdy1 = !v1_q || rdy2;
        rdy0 = !v0_q || rdy1;
    end

    assign in_ready  = rdy0;
    assign out_valid = v2_q;
    assign q         = q_q;
    assign ovf       = ovf_q;
    assign out_count = cnt_q;

    // Arithmetic of stages 1 and 2; widths are chosen so no carry is ever dropped
    always_comb begin
        sum_ab = {1'b0, a0_q} + {1'b0, b0_q};
        s1_w   = S1W'(sum_ab) << SHIFT;
        full_w = FW'(s1_q) + FW'(c1_q);
    end

    // Reduce the full-precision result to the output width
    generate
        if (OW == FW) begin : g_exact
            assign q_red   = full_w;
            assign ovf_red = 1'b0;
        end else begin : g_reduce
            logic unused_hi;
            assign unused_hi = ^full_w[FW-1:OW];
`ifdef ADD_SHIFT_SAT_EN
            assign ovf_red = |full_w[FW-1:OW];
            assign q_red   = ovf_red ? {OW{1'b1}} : full_w[OW-1:0];
`else
            assign ovf_red = 1'b0;
            assign q_red   = full_w[OW-1:0];
`endif
        end
    endgenerate

    // Next-state for every stage: advance on ready, collapse bubbles, count output handshakes
    always_comb begin
        v0_d  = v0_q;
        a0_d  = a0_q;
        b0_d  = b0_q;
        c0_d  = c0_q;
        v1_d  = v1_q;
        s1_d  = s1_q;
        c1_d  = c1_q;
        v2_d  = v2_q;
        q_d   = q_q;
        ovf_d = ovf_q;
        cnt_d = cnt_q;

        if (rdy0) begin
            v0_d = in_valid;
            if (in_valid) begin
                a0_d = a_in;
                b0_d = b_in;
                c0_d = c_in;
            end
        end

        if (rdy1) begin
            v1_d = v0_q;
            if (v0_q) begin
                s1_d = s1_w;
                c1_d = c0_q;
            end
        end

        if (rdy2) begin
            v2_d = v1_q;
            if (v1_q) begin
                q_d   = q_red;
                ovf_d = ovf_red;
            end
        end

        if (v2_q && out_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Pipeline registers, cleared asynchronously so in-flight triples are discarded on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q  <= 1'b0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            a0_q  <= '0;
            b0_q  <= '0;
            c0_q  <= '0;
            s1_q  <= '0;
            c1_q  <= '0;
            q_q   <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            v0_q  <= v0_d;
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            a0_q  <= a0_d;
            b0_q  <= b0_d;
            c0_q  <= c0_d;
            s1_q  <= s1_d;
            c1_q  <= c1_d;
            q_q   <= q_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_add_shift_add_pipe.sv
// tb/tb_add_shift_add_pipe.sv - randomized scoreboard bench for add_shift_add_pipe
module tb_add_shift_add_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, ovf;
    logic [31:0] a, b, c;
    logic [35:0] q;
    logic [15:0] out_count;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, ovf2;
    logic [31:0] a2, b2, c2;
    logic [33:0] q2;
    logic [3:0]  cnt2;

    add_shift_add_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a), .b_in(b), .c_in(c), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .ovf(ovf), .out_count(out_count)
    );

    add_shift_add_pipe #(.W(32), .SHIFT(2), .OW(34), .CNTW(4)) dut_n (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a_in(a2), .b_in(b2), .c_in(c2), .out_valid(out_valid2), .out_ready(out_ready2),
        .q(q2), .ovf(ovf2), .out_count(cnt2)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic, then saturate or truncate to ow bits; {ovf, q}
    function automatic logic [64:0] model(input logic [63:0] x, input logic [63:0] y,
                                          input logic [63:0] z, input int ow);
        logic [63:0] full;
        logic [63:0] maxv;
        full = ((x + y) << 2) + z;
        maxv = (64'd1 << ow) - 64'd1;
`ifdef ADD_SHIFT_SAT_EN
        if (full > maxv) return {1'b1, maxv};
        return {1'b0, full};
`else
        return {1'b0, full & maxv};
`endif
    endfunction

    logic [64:0] exp_q[$];
    logic [64:0] exp2_q[$];
    int          acc_cnt = 0;
    int          dlv_cnt = 0;
    int          cnt_model = 0;
    int          cyc = 0;
    bit          hold_valid = 0;
    logic [35:0] hold_q;

    // One clock cycle of the main DUT: observe handshakes just before the edge, end at next negedge
    task automatic cycle();
        logic [64:0] e;
        #1;
        if (out_valid && !out_ready) begin
            if (hold_valid) check("hold_q", q, hold_q);
            hold_valid = 1;
            hold_q = q;
        end else begin
            hold_valid = 0;
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, c, 36));
            acc_cnt++;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("q", q, e[63:0]);
                check("ovf", ovf, e[64]);
            end
            dlv_cnt++;
            cnt_model++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            cycle();
            guard++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int acc0, dlv0, cyc0, n2;
        logic [64:0] e2;
        rst_n = 0; in_valid = 0; out_ready = 0; a = 0; b = 0; c = 0;
        in_valid2 = 0; out_ready2 = 0; a2 = 0; b2 = 0; c2 = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_q", q, 0);
        check("rst_ovf", ovf, 0);
        check("rst_count", out_count, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // 1: basic latency, out_valid appears on the third edge
        a = 1; b = 2; c = 3; in_valid = 1; out_ready = 1;
        cycle();
        in_valid = 0;
        check("t1_valid_e1", out_valid, 0);
        cycle();
        check("t1_valid_e2", out_valid, 0);
        cycle();
        check("t1_valid_e3", out_valid, 1);
        check("t1_q", q, 64'hF);
        drain();

        // 2: all ones, then 100 random back-to-back triples at full throughput
        acc0 = acc_cnt; dlv0 = dlv_cnt; cyc0 = cyc;
        a = '1; b = '1; c = '1; in_valid = 1;
        #1;
        check("t2_in_ready", in_ready, 1);
        cycle();
        for (int i = 0; i < 100; i++) begin
            a = $urandom; b = $urandom; c = $urandom;
            cycle();
        end
        in_valid = 0;
        drain();
        check("t2_accepted", acc_cnt - acc0, 101);
        check("t2_delivered", dlv_cnt - dlv0, 101);
        check("t2_cycles", cyc - cyc0, 104);
        check("t2_count", out_count, 64'(cnt_model));

        // 3: backpressure, exactly three accepted, then release
        acc0 = acc_cnt; dlv0 = dlv_cnt;
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom; c = $urandom;
            cycle();
        end
        #1;
        check("t3_in_ready", in_ready, 0);
        check("t3_accepted", acc_cnt - acc0, 3);
        in_valid = 0; out_ready = 1;
        drain();
        check("t3_delivered", dlv_cnt - dlv0, 3);
        check("t3_count", out_count, 64'(cnt_model));

        // 5: asynchronous reset with three triples in flight
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom; c = $urandom;
            cycle();
        end
        in_valid = 0;
        #2;
        rst_n = 0;
        #1;
        check("t5_valid", out_valid, 0);
        check("t5_q", q, 0);
        check("t5_count", out_count, 0);
        exp_q.delete();
        cnt_model = 0;
        hold_valid = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        a = 4; b = 4; c = 0; in_valid = 1; out_ready = 1;
        cycle();
        in_valid = 0;
        cycle();
        cycle();
        check("t5_post_valid", out_valid, 1);
        check("t5_post_q", q, 32);
        drain();
        check("t5_post_count", out_count, 1);

        // 4 and 6: narrow output (OW=34) and 4-bit wrapping counter
        n2 = 0;
        in_valid2 = 1; out_ready2 = 1;
        a2 = '1; b2 = '1; c2 = '1;
        for (int i = 0; i < 40 && n2 < 17; i++) begin
            if (i == 17) in_valid2 = 0;
            #1;
            if (in_valid2 && in_ready2) exp2_q.push_back(model(a2, b2, c2, 34));
            if (out_valid2 && out_ready2) begin
                if (exp2_q.size() == 0) begin
                    check("t6_spurious", 64'd1, 64'd0);
                end else begin
                    e2 = exp2_q.pop_front();
                    check("t4_q", q2, e2[63:0]);
                    check("t4_ovf", ovf2, e2[64]);
                end
                if (n2 == 0) begin
`ifdef ADD_SHIFT_SAT_EN
                    check("t4_q_const", q2, 64'h3FFFFFFFF);
                    check("t4_ovf_const", ovf2, 1);
`else
                    check("t4_q_const", q2, 64'h0FFFFFFF7);
                    check("t4_ovf_const", ovf2, 0);
`endif
                end
                n2++;
                @(posedge clk);
                @(negedge clk);
                if (n2 >= 15) check($sformatf("t6_count_%0d", n2), cnt2, 64'(n2 % 16));
            end else begin
                @(posedge clk);
                @(negedge clk);
            end
            a2 = $urandom; b2 = $urandom; c2 = $urandom;
        end
        check("t6_handshakes", n2, 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
